// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS pattern checker: FSM states and the
// reference N=4 / TAPS=1001 sequence emitted by the matching generator.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Generator output from seed 1111; bit i is the i-th emitted bit.
  localparam int unsigned REF_LEN = 15;
  localparam logic [REF_LEN-1:0] REF_SEQ = 15'b000100110101111;

endpackage

// File: rtl/prbs_checker_lfsr_tap_xor.sv
// Fibonacci LFSR feedback: XOR of the history bits selected by the tap mask.
module lfsr_tap_xor #(
  parameter int unsigned   N    = 4,
  parameter logic [N-1:0]  TAPS = 4'b1001
) (
  input  logic [N-1:0] h,
  output logic         pred
);

  assign pred = ^(h & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: acquires lock on an LFSR bit stream, then
// flywheels the local LFSR and counts departures from the expected sequence.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned  N           = 4,
  parameter logic [N-1:0] TAPS        = 4'b1001,
  parameter int unsigned  LOCK_CNT    = 16,
  parameter int unsigned  WIN         = 32,
  parameter int unsigned  LOSS_THRESH = 4,
  parameter int unsigned  ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WW = $clog2(WIN + 1);
  localparam int unsigned EW = $clog2(LOSS_THRESH + 1);

  state_t          state, state_n;
  logic [N-1:0]    h, h_n, h_shift;
  logic [FW-1:0]   fill, fill_n;
  logic [MW-1:0]   match, match_n;
  logic [WW-1:0]   win, win_n;
  logic [EW-1:0]   werr, werr_n;
  logic            err_pulse_n, sync_lost_n, err_inc;
  logic [ERR_W-1:0] err_count_n;
  logic            pred;

  lfsr_tap_xor #(
    .N    (N),
    .TAPS (TAPS)
  ) u_tap_xor (
    .h    (h),
    .pred (pred)
  );

  always_comb begin
    state_n     = state;
    h_n         = h;
    fill_n      = fill;
    match_n     = match;
    win_n       = win;
    werr_n      = werr;
    err_pulse_n = 1'b0;
    sync_lost_n = 1'b0;
    err_inc     = 1'b0;
    h_shift     = {in_bit, h[N-1:1]};
    if (in_valid) begin
      unique case (state)
        SEARCH: begin
          h_n    = h_shift;
          fill_n = fill + 1'b1;
          if (fill + 1'b1 == FW'(N)) begin
            state_n = VERIFY;
            fill_n  = '0;
            match_n = '0;
          end
        end
        VERIFY: begin
          h_n = h_shift;
          if (h_shift == '0 || in_bit != pred) begin
            match_n = '0;
          end else if (match + 1'b1 == MW'(LOCK_CNT)) begin
            state_n = LOCKED;
            match_n = '0;
            win_n   = '0;
            werr_n  = '0;
          end else begin
            match_n = match + 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel: the local LFSR advances on its own prediction, so a
          // corrupted input bit never propagates into later predictions.
          h_n   = {pred, h[N-1:1]};
          win_n = win + 1'b1;
          if (in_bit != pred) begin
            err_pulse_n = 1'b1;
            err_inc     = 1'b1;
            werr_n      = werr + 1'b1;
          end
          if (werr_n == EW'(LOSS_THRESH)) begin
            state_n     = SEARCH;
            fill_n      = '0;
            sync_lost_n = 1'b1;
            win_n       = '0;
            werr_n      = '0;
          end else if (win_n == WW'(WIN)) begin
            win_n  = '0;
            werr_n = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    err_count_n = err_count;
    if (clear_cnt) begin
      err_count_n = '0;
    end else if (err_inc && err_count != '1) begin
      err_count_n = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      h         <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      werr      <= '0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill      <= fill_n;
      match     <= match_n;
      win       <= win_n;
      werr      <= werr_n;
      err_pulse <= err_pulse_n;
      sync_lost <= sync_lost_n;
      err_count <= err_count_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a sequence-level reference model predicts
// each cycle's outputs; a monitor compares them against two DUT instances.
module tb_prbs_checker;
  import prbs_checker_pkg::*;

  localparam int unsigned LOCK_CNT    = 16;
  localparam int unsigned WIN         = 32;
  localparam int unsigned LOSS_THRESH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse, sync_lost;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s, sync_lost_s;
  logic [3:0]  err_count_s;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
    .sync_lost(sync_lost), .err_count(err_count)
  );

  prbs_checker #(.ERR_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked_s), .err_pulse(err_pulse_s),
    .sync_lost(sync_lost_s), .err_count(err_count_s)
  );

  typedef struct {
    bit          lk;
    bit          pulse;
    bit          lost;
    int unsigned cnt;
    int unsigned cnt_s;
  } exp_t;

  exp_t sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  bit [REF_LEN-1:0] ref_seq = REF_SEQ;
  int unsigned gen_idx = 0;
  bit          m_locked = 0;
  bit          hist[$];
  int unsigned run = 0;
  int unsigned exp_idx = 0;
  int unsigned nlock = 0;
  int unsigned wcnt = 0;
  int unsigned cnt_big = 0;
  int unsigned cnt_small = 0;

  function automatic bit gen_next();
    bit b = ref_seq[gen_idx];
    gen_idx = (gen_idx + 1) % REF_LEN;
    return b;
  endfunction

  // Locate the generator phase whose four bits match the last four received.
  function automatic int unsigned find_next();
    int unsigned s = hist.size();
    for (int unsigned p = 0; p < REF_LEN; p++) begin
      if (ref_seq[p] == hist[s-4] && ref_seq[(p+1)%REF_LEN] == hist[s-3] &&
          ref_seq[(p+2)%REF_LEN] == hist[s-2] && ref_seq[(p+3)%REF_LEN] == hist[s-1])
        return (p + 4) % REF_LEN;
    end
    return 0;
  endfunction

  function automatic exp_t model_step(bit rst, bit v, bit b, bit clr);
    exp_t e;
    bit inc = 0;
    bit ok;
    e.pulse = 0;
    e.lost  = 0;
    if (rst) begin
      m_locked = 0; hist.delete(); run = 0; cnt_big = 0; cnt_small = 0;
    end else begin
      if (v) begin
        if (!m_locked) begin
          hist.push_back(b);
          if (hist.size() > 5) void'(hist.pop_front());
          if (hist.size() == 5) begin
            ok = (b == (hist[0] ^ hist[3])) && (hist[1] | hist[2] | hist[3] | hist[4]);
            run = ok ? run + 1 : 0;
            if (run == LOCK_CNT) begin
              m_locked = 1; exp_idx = find_next(); nlock = 0; wcnt = 0; run = 0;
            end
          end
        end else begin
          if (b != ref_seq[exp_idx]) begin
            e.pulse = 1; inc = 1; wcnt++;
          end
          exp_idx = (exp_idx + 1) % REF_LEN;
          nlock++;
          if (wcnt == LOSS_THRESH) begin
            m_locked = 0; e.lost = 1; hist.delete(); run = 0;
          end else if (nlock % WIN == 0) begin
            wcnt = 0;
          end
        end
      end
      if (clr) begin
        cnt_big = 0; cnt_small = 0;
      end else if (inc) begin
        if (cnt_big < 65535) cnt_big++;
        if (cnt_small < 15) cnt_small++;
      end
    end
    e.lk    = m_locked;
    e.cnt   = cnt_big;
    e.cnt_s = cnt_small;
    return e;
  endfunction

  task automatic step(input bit rst, input bit v, input bit b, input bit clr);
    @(posedge clk);
    #2;
    reset = rst; in_valid = v; in_bit = b; clear_cnt = clr;
    sb.push_back(model_step(rst, v, b, clr));
  endtask

  task automatic clean(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 1, gen_next(), 0);
  endtask

  task automatic bad();
    step(0, 1, ~gen_next(), 0);
  endtask

  function automatic void chk(string nm, int unsigned act, int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked",      32'(locked),      32'(e.lk));
        chk("err_pulse",   32'(err_pulse),   32'(e.pulse));
        chk("sync_lost",   32'(sync_lost),   32'(e.lost));
        chk("err_count",   32'(err_count),   e.cnt);
        chk("locked_s",    32'(locked_s),    32'(e.lk));
        chk("err_count_s", 32'(err_count_s), e.cnt_s);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    clean(25);                              // acquisition: lock after 20th bit
    clean(10); bad(); clean(20);            // single isolated error
    bad(); clean(2); bad(); clean(1); bad(); clean(2); bad();
    clean(30);                              // loss of lock, then reacquire
    step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin      // gapped stream 1,0,0,1
      step(0, 1, gen_next(), 0);
      step(0, 0, 1'($urandom), 0);
      step(0, 0, 1'($urandom), 0);
      step(0, 1, gen_next(), 0);
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin      // saturation of the 4-bit counter
      clean(11); bad();
    end
    clean(3);
    step(0, 1, ~gen_next(), 1);             // clear coincident with an error
    clean(5);
    for (int i = 0; i < 400; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      bit err = ($urandom_range(0, 29) == 0);
      bit clr = ($urandom_range(0, 59) == 0);
      if (v) step(0, 1, gen_next() ^ err, clr);
      else   step(0, 0, 1'($urandom), clr);
    end
    step(1, 0, 0, 0);
    clean(25);
    clean(3);
    step(1, 1, gen_next(), 0);              // reset while locked
    clean(25);
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receiver-side counterpart of the team's Fibonacci LFSR pattern generator.
- Takes the serial bit stream the generator emits (its q[0] each step), self-synchronises to it, and flags every bit that departs from the expected LFSR sequence.
- Used as the pattern checker in link and loopback tests, with lock status and a saturating error count for a status register.

Parameters:
- N, 4: LFSR length in bits.
- TAPS, 4'b1001: tap mask, N bits wide; must equal the generator's mask.
- LOCK_CNT, 16: consecutive correct predictions needed to declare lock.
- WIN, 32: window length in valid bits for loss-of-lock evaluation while locked.
- LOSS_THRESH, 4: errors within one window that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies in_bit; the checker does nothing on cycles where it is low.
- in_bit  in  1  received serial bit.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED.
- sync_lost  out  1  one-cycle pulse on the LOCKED->SEARCH transition.
- err_count  out  ERR_W  saturating count of mismatches while LOCKED.

Behaviour:
- Reset values: locked=0, err_pulse=0, sync_lost=0, err_count=0, state=SEARCH, h=0, all internal counters 0.
- History register h[N-1:0]: h[0] holds the oldest bit, h[N-1] the newest. Shift is h <= {new_bit, h[N-1:1]}.
- Prediction: pred = XOR of h[i] over every i with TAPS[i]=1. This holds because b(t+N) = XOR over taps of b(t+i).
- Latency: all outputs are registered and reflect the valid bit sampled on the previous edge.
- SEARCH: shift in_bit into h; fill++. When fill reaches N, go to VERIFY and set match=0.
- VERIFY: compare in_bit with pred and shift in_bit into h.
  - Match: match++. When match reaches LOCK_CNT, go to LOCKED with win=0 and werr=0.
  - Mismatch: match=0; stay in VERIFY (self-resynchronises from the received bits).
  - If the next h would be all-zero, match=0. An all-zero stream therefore never locks.
- LOCKED (flywheel): h shifts in pred, not in_bit, so one corrupted bit causes exactly one error.
  - Mismatch: err_pulse=1; err_count++ (holds at 2^ERR_W-1); werr++.
  - Every valid bit: win++. When win reaches WIN, win=0 and werr=0.
  - When werr reaches LOSS_THRESH: go to SEARCH with fill=0, locked=0, sync_lost=1. The triggering error is still counted and pulsed.
  - The loss check takes priority over the window rollover on the same bit.
- Errors are never counted or pulsed in SEARCH or VERIFY.
- clear_cnt: err_count <= 0 on that edge, and clear takes priority over a coincident increment. State and lock are unaffected.
- reset at any point, including mid-lock: every register returns to its reset value on that edge.
- in_valid=0: state, h and all counters hold. err_pulse and sync_lost are 0.

Decomposition:
- Shared package/include: state encodings (SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2) and the reference test sequence constant for N=4/TAPS=1001.
- One natural sub-module, lfsr_tap_xor: parameterised N/TAPS, combinational, h in -> pred out. It is reusable by the generator.

Test Plan:
- Lock acquisition: reset, then stream the generator sequence from seed 1111 (period 15: 1,1,1,1,0,1,0,1,1,0,0,1,0,0,0, repeated), in_valid=1 continuously -> locked rises after the 20th valid bit (4 fill + 16 matches); err_count=0.
- Single bit error while locked: invert one bit -> exactly one err_pulse, err_count=1, no follow-on errors, locked stays 1.
- Loss of lock: invert 4 bits within 32 valid bits -> 4 err_pulses, sync_lost pulses with the 4th, locked=0, err_count=4. With a clean stream afterwards, locked returns 20 valid bits later.
- All-zero and gapped input: 100 zero bits -> locked never asserts. Clean stream with in_valid toggling 1,0,0,1 -> lock after exactly 20 valid bits, and gaps cause no errors.
- Counter edge cases: ERR_W=4 with 20 isolated errors (fewer than 4 per window) -> err_count saturates at 15. clear_cnt asserted on the same cycle as an error -> err_count=0.
- Reset while LOCKED -> next cycle locked=0, err_count=0, and reacquisition takes 20 valid bits.
